pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage MIPS32 pipeline.
- Drives stall/flush of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, ID-stage taken branches, and multi-cycle L1 I-cache/D-cache misses via a wait-state FSM.
- Sits beside the pipeline registers, fed by decode, EX load info and both cache controllers.

---
 rtl/pipe_pkg.sv | 10 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 14 +
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encodings and register constants for the pipeline hazard controller
package pipe_pkg;
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      I_WAIT  = 2'd1,
      D_WAIT  = 2'd2,
      ID_WAIT = 2'd3
   } state_t;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the load in EX and the operands read in ID
module hazard_detect
   import pipe_pkg::*;
(
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   output logic       load_use
);
   assign load_use = ex_mem_read && ex_rt != REG_ZERO &&
                     (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use, ID branches and I/D-cache miss waits
// Perf counters are built only when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int TMO_CYCLES = 1023,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             id_branch_taken,
   input  logic             icache_miss,
   input  logic             icache_ready,
   input  logic             dcache_miss,
   input  logic             dcache_ready,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic             mem_wb_flush,
   output logic [1:0]       ctrl_state,
   output logic             timeout_err,
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_flush_cnt
);
   localparam int TW = $clog2(TMO_CYCLES + 1);
   localparam logic [TW-1:0] TMO = TW'(TMO_CYCLES);
   state_t state, state_nxt;
   logic [TW-1:0] tmo_cnt;
   logic load_use, d_wait, i_wait;
   hazard_detect u_hazard_detect (
      .ex_mem_read(ex_mem_read),
      .ex_rt      (ex_rt),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .load_use   (load_use)
   );
   assign ctrl_state = state;
   // A ready cycle ends that side's wait, so outputs fall through to lower-priority rules
   assign d_wait = (state == RUN && dcache_miss) ||
                   ((state == D_WAIT || state == ID_WAIT) && !dcache_ready);
   assign i_wait = (state == RUN && icache_miss) ||
                   ((state == I_WAIT || state == ID_WAIT) && !icache_ready);
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     state_nxt = dcache_miss ? (icache_miss ? ID_WAIT : D_WAIT) : (icache_miss ? I_WAIT : RUN);
         I_WAIT:  state_nxt = icache_ready ? RUN : (dcache_miss ? ID_WAIT : I_WAIT);
         D_WAIT:  state_nxt = dcache_ready ? (icache_miss ? I_WAIT : RUN) : D_WAIT;
         ID_WAIT: state_nxt = dcache_ready ? (icache_ready ? RUN : I_WAIT) : (icache_ready ? D_WAIT : ID_WAIT);
         default: state_nxt = RUN;
      endcase
   end
   always_comb begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_stall = 1'b0;
      mem_wb_flush = 1'b0;
      if (rst) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (d_wait) begin
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (i_wait || load_use) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
      end else begin
         if_id_flush = id_branch_taken;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         tmo_cnt     <= (state_nxt == RUN) ? '0 : (state != RUN && tmo_cnt != TMO) ? tmo_cnt + TW'(1) : tmo_cnt;
         timeout_err <= timeout_err || (state != RUN && tmo_cnt >= TMO - TW'(1));
      end
   end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         perf_stall_cnt <= perf_stall_cnt + CNT_W'(pc_stall);
         perf_flush_cnt <= perf_flush_cnt + CNT_W'(if_id_flush);
      end
   end
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif
endmodule
